// File: rtl/exc_seq_if.sv
// Decode-side inputs and CP0/PC-side outputs of the trap/return sequencer.
// The slave modport is the sequencer; the master modport is the datapath/CP0 side.
interface exc_seq_if #(
  parameter int CNT_W = 16
);
  logic             inst_valid;
  logic             is_syscall;
  logic             is_break;
  logic             is_teq;
  logic             is_eret;
  logic             teq_eq;
  logic [31:0]      pc;
  logic [31:0]      status;
  logic [31:0]      exc_addr;
  logic             cp0_exception;
  logic             cp0_eret;
  logic [4:0]       cp0_cause;
  logic [31:0]      cp0_pc;
  logic             stall;
  logic             pc_load;
  logic [31:0]      pc_target;
  logic [CNT_W-1:0] trap_cnt;

  modport master (
    output inst_valid, is_syscall, is_break, is_teq, is_eret, teq_eq, pc, status, exc_addr,
    input  cp0_exception, cp0_eret, cp0_cause, cp0_pc, stall, pc_load, pc_target, trap_cnt
  );

  modport slave (
    input  inst_valid, is_syscall, is_break, is_teq, is_eret, teq_eq, pc, status, exc_addr,
    output cp0_exception, cp0_eret, cp0_cause, cp0_pc, stall, pc_load, pc_target, trap_cnt
  );
endinterface

// File: rtl/exc_seq.sv
// Trap/ERET sequencer feeding CP0; trap takes 4 cycles (C0-C3), ERET 2 cycles (C0-C1).
// No backpressure input: stall is raised for the whole sequence to freeze fetch and writes.
module exc_seq #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0040_0004,
  parameter int          CNT_W        = 16
) (
  input logic       clk,
  input logic       rst_n,
  exc_seq_if.slave  bus
);
  typedef enum logic [2:0] {
    IDLE,
    TRAP_LATCH,
    TRAP_COMMIT,
    TRAP_JUMP,
    ERET_RET
  } state_t;

  state_t           state;
  logic             busy;
  logic             exc_q;
  logic             eret_q;
  logic             pc_load_q;
  logic [4:0]       cause_q;
  logic [31:0]      epc_q;
  logic [CNT_W-1:0] cnt_q;

  logic       sys_en;
  logic       brk_en;
  logic       teq_en;
  logic       trap_req;
  logic       eret_req;
  logic [4:0] cause_sel;
  logic       unused_status;

  assign unused_status = ^bus.status[31:4];

  // Requests are gated by rst_n so every output reads 0 while reset is held.
  always_comb begin
    sys_en    = bus.is_syscall & bus.status[1];
    brk_en    = bus.is_break & bus.status[2];
    teq_en    = bus.is_teq & bus.teq_eq & bus.status[3];
    trap_req  = rst_n & bus.inst_valid & bus.status[0] & (sys_en | brk_en | teq_en);
    eret_req  = rst_n & bus.inst_valid & bus.is_eret & ~trap_req;
    cause_sel = sys_en ? 5'd8 : (brk_en ? 5'd9 : 5'd13);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      exc_q     <= 1'b0;
      eret_q    <= 1'b0;
      pc_load_q <= 1'b0;
      cause_q   <= 5'd0;
      epc_q     <= 32'd0;
      cnt_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (trap_req) begin
            state   <= TRAP_LATCH;
            busy    <= 1'b1;
            cause_q <= cause_sel;
            epc_q   <= bus.pc;
          end else if (eret_req) begin
            state     <= ERET_RET;
            busy      <= 1'b1;
            eret_q    <= 1'b1;
            pc_load_q <= 1'b1;
          end
        end
        TRAP_LATCH: begin
          state <= TRAP_COMMIT;
          exc_q <= 1'b1;
          if (cnt_q != '1) cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        TRAP_COMMIT: begin
          state     <= TRAP_JUMP;
          exc_q     <= 1'b0;
          pc_load_q <= 1'b1;
        end
        TRAP_JUMP: begin
          state     <= IDLE;
          busy      <= 1'b0;
          pc_load_q <= 1'b0;
        end
        ERET_RET: begin
          state     <= IDLE;
          busy      <= 1'b0;
          eret_q    <= 1'b0;
          pc_load_q <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          exc_q     <= 1'b0;
          eret_q    <= 1'b0;
          pc_load_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cp0_exception = exc_q;
  assign bus.cp0_eret      = eret_q;
  assign bus.cp0_cause     = cause_q;
  assign bus.cp0_pc        = epc_q;
  assign bus.pc_load       = pc_load_q;
  assign bus.trap_cnt      = cnt_q;
  assign bus.stall         = busy | ((state == IDLE) & (trap_req | eret_req));
  // CP0 only drives EPC onto exc_addr while eret is high, so the return target is passed through live.
  assign bus.pc_target     = !pc_load_q ? 32'd0 :
                             ((state == ERET_RET) ? bus.exc_addr : HANDLER_ADDR);
endmodule
